// File: rtl/parity_history_pkg.sv
// Shared types and constants for parity_history.
// No logic of its own; the default geometry comes from parity_defs.vh.
// Optional check path is controlled by the PARITY_CHECK_EN macro in the top.
`include "parity_defs.vh"

package parity_history_pkg;

    localparam int DEF_WIDTH = `PARITY_DEF_WIDTH;
    localparam int DEF_DEPTH = `PARITY_DEF_DEPTH;

    localparam logic MODE_EVEN = `PARITY_EVEN;
    localparam logic MODE_ODD  = `PARITY_ODD;

endpackage

// File: rtl/parity_defs.vh
// Shared constants for the parity history block: parity mode encodings and default geometry.
// Included by the RTL package and by the bench so both agree on the defaults.
// Guarded so that several files in one compilation unit can include it.
`ifndef PARITY_DEFS_VH
`define PARITY_DEFS_VH

`define PARITY_EVEN 1'b0
`define PARITY_ODD  1'b1

`define PARITY_DEF_WIDTH 8
`define PARITY_DEF_DEPTH 8

`endif

// File: rtl/parity_history_word.sv
// Word parity: reduction XOR of d, inverted when odd parity is requested.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module parity_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  logic             odd,
    output logic             par
);

    // Even mode gives ^d; odd mode flips it so the word plus bit has odd weight.
    always_comb begin
        par = (^d) ^ odd;
    end

endmodule

// File: rtl/parity_history.sv
// Parity history: shifts the parity bit of each loaded word into a DEPTH-deep history,
// keeps a running column XOR (lrc) and a saturating load count. Latency: one clock.
// Backpressure: none; ld is always accepted. Optional check path: PARITY_CHECK_EN.
module parity_history
    import parity_history_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic             clr,
    input  logic             odd,
    input  logic [WIDTH-1:0] d,
`ifdef PARITY_CHECK_EN
    input  logic             chk,
    input  logic             p_in,
    output logic             err,
`endif
    output logic [DEPTH-1:0] parity,
    output logic [WIDTH-1:0] lrc,
    output logic [CW-1:0]    count,
    output logic             full
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic          ld_par;
    logic [CW-1:0] count_nxt;

    // One parity generator for the load path; the check path shares its result
    // since both look at the same d/odd on the same edge.
    parity_word #(.WIDTH(WIDTH)) u_ld_par (
        .d   (d),
        .odd (odd),
        .par (ld_par)
    );

    // Saturating increment; full is derived from this so it lands on the same edge as count.
    always_comb begin
        count_nxt = count;
        if (count != CNT_MAX) begin
            count_nxt = count + CW'(1);
        end
    end

    // Main state: clr beats ld, ld beats hold; reset discards everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity <= '0;
            lrc    <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else if (clr) begin
            parity <= '0;
            lrc    <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else if (ld) begin
            parity <= {parity[DEPTH-2:0], ld_par};
            lrc    <= lrc ^ d;
            count  <= count_nxt;
            full   <= (count_nxt == CNT_MAX);
        end
    end

`ifdef PARITY_CHECK_EN
    // Sticky mismatch flag between the received parity bit and the one computed locally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (chk && (p_in != ld_par)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_parity_history.sv
// Bench for parity_history: directed loads, a queue-based reference model checked every negedge,
// plus hand-computed literal expectations. Optional check path follows PARITY_CHECK_EN.
// Runs to completion on its own; a watchdog bounds the run.
`include "parity_defs.vh"

module tb_parity_history;

    localparam int W  = `PARITY_DEF_WIDTH;
    localparam int D  = `PARITY_DEF_DEPTH;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ld = 1'b0;
    logic          clr = 1'b0;
    logic          odd = `PARITY_EVEN;
    logic [W-1:0]  d = '0;
    logic [D-1:0]  parity;
    logic [W-1:0]  lrc;
    logic [CW-1:0] count;
    logic          full;
`ifdef PARITY_CHECK_EN
    logic          chk = 1'b0;
    logic          p_in = 1'b0;
    logic          err;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    parity_history #(.WIDTH(W), .DEPTH(D)) dut (
        .clk    (clk),
        .reset  (reset),
        .ld     (ld),
        .clr    (clr),
        .odd    (odd),
        .d      (d),
`ifdef PARITY_CHECK_EN
        .chk    (chk),
        .p_in   (p_in),
        .err    (err),
`endif
        .parity (parity),
        .lrc    (lrc),
        .count  (count),
        .full   (full)
    );

    always #5 clk = ~clk;

    // Reference model: list of parity bits (newest first), list of loaded words, load tally.
    bit         m_bits[$];
    logic [W-1:0] m_words[$];
    int         m_loads = 0;
    bit         m_err = 0;

    task automatic m_clear();
        m_bits.delete();
        m_words.delete();
        m_loads = 0;
        m_err = 0;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_clear();
        end else if (clr) begin
            m_clear();
        end else begin
`ifdef PARITY_CHECK_EN
            if (chk && (p_in != ((^d) ^ odd))) m_err = 1;
`endif
            if (ld) begin
                m_bits.push_front((^d) ^ odd);
                if (m_bits.size() > D) void'(m_bits.pop_back());
                m_words.push_back(d);
                m_loads++;
            end
        end
    end

    function automatic logic [D-1:0] exp_parity();
        logic [D-1:0] v = '0;
        foreach (m_bits[i]) v[i] = m_bits[i];
        return v;
    endfunction

    function automatic logic [W-1:0] exp_lrc();
        logic [W-1:0] v = '0;
        foreach (m_words[i]) v ^= m_words[i];
        return v;
    endfunction

    function automatic int exp_count();
        return (m_loads > D) ? D : m_loads;
    endfunction

    task automatic cmp(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Every negedge: outputs must match the model.
    always @(negedge clk) begin
        cmp("mdl_parity", parity, exp_parity());
        cmp("mdl_lrc",    lrc,    exp_lrc());
        cmp("mdl_count",  count,  exp_count());
        cmp("mdl_full",   full,   (m_loads >= D));
`ifdef PARITY_CHECK_EN
        cmp("mdl_err",    err,    m_err);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v, input logic o);
        ld = 1'b1; d = v; odd = o;
        step();
        ld = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, time %0t, limit 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a pending load: nothing may change.
        ld = 1'b1; d = 8'hFF;
        #100;
        cmp("rst_parity", parity, 0);
        cmp("rst_lrc",    lrc,    0);
        cmp("rst_count",  count,  0);
        cmp("rst_full",   full,   0);
        @(posedge clk); #1;
        ld = 1'b0; reset = 1'b1;
        step();

        // 07,03,01 even parity -> bits 1,0,1 -> 101.
        load(8'h07, `PARITY_EVEN);
        load(8'h03, `PARITY_EVEN);
        load(8'h01, `PARITY_EVEN);
        @(negedge clk);
        cmp("seq_parity", parity, 8'h05);
        cmp("seq_lrc",    lrc,    8'h05);
        cmp("seq_count",  count,  3);
        cmp("seq_full",   full,   0);
        do_clr();

        // Fill to saturation and one beyond.
        for (int i = 0; i < 8; i++) load(8'h01, `PARITY_EVEN);
        @(negedge clk);
        cmp("fill8_count", count, 8);
        cmp("fill8_full",  full,  1);
        load(8'h01, `PARITY_EVEN);
        @(negedge clk);
        cmp("fill9_parity", parity, 8'hFF);
        cmp("fill9_count",  count,  8);
        cmp("fill9_full",   full,   1);
        cmp("fill9_lrc",    lrc,    8'h01);

        // Saturated history still shifts: a zero-parity word enters bit 0.
        load(8'h03, `PARITY_EVEN);
        @(negedge clk);
        cmp("sat_shift", parity, 8'hFE);
        do_clr();

        // Zero word: odd mode gives 1, even mode gives 0.
        load(8'h00, `PARITY_ODD);
        load(8'h00, `PARITY_EVEN);
        @(negedge clk);
        cmp("zero_parity", parity, 8'h02);
        cmp("zero_lrc",    lrc,    8'h00);
        cmp("zero_count",  count,  2);
        do_clr();

        // clr wins over a simultaneous load.
        load(8'h11, `PARITY_EVEN);
        load(8'h22, `PARITY_ODD);
        load(8'h33, `PARITY_EVEN);
        clr = 1'b1; ld = 1'b1; d = 8'hFF;
        step();
        clr = 1'b0; ld = 1'b0;
        @(negedge clk);
        cmp("clrld_parity", parity, 0);
        cmp("clrld_lrc",    lrc,    0);
        cmp("clrld_count",  count,  0);
        cmp("clrld_full",   full,   0);

        // Load, then reset between edges: outputs clear before the next edge.
        load(8'h5A, `PARITY_EVEN);
        #2;
        cmp("pre_arst_count", count, 1);
        reset = 1'b0;
        #1;
        cmp("arst_parity", parity, 0);
        cmp("arst_lrc",    lrc,    0);
        cmp("arst_count",  count,  0);
        cmp("arst_full",   full,   0);
        @(posedge clk); #1;
        reset = 1'b1;
        step();

`ifdef PARITY_CHECK_EN
        // 03 even parity is 0; p_in=1 mismatches.
        chk = 1'b1; d = 8'h03; odd = `PARITY_EVEN; p_in = 1'b1;
        step();
        chk = 1'b0;
        @(negedge clk);
        cmp("chk_err_set", err, 1);
        cmp("chk_no_load", count, 0);
        chk = 1'b1; p_in = 1'b0;
        step();
        chk = 1'b0;
        @(negedge clk);
        cmp("chk_sticky", err, 1);
        do_clr();
        @(negedge clk);
        cmp("chk_clr", err, 0);
        chk = 1'b1; d = 8'h03; p_in = 1'b0;
        step();
        chk = 1'b0;
        @(negedge clk);
        cmp("chk_match", err, 0);
`endif

        step();
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
